execute_muldiv_seq: RTL and testbench
=====================================

Name: execute_muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M (OP opcode 0110011, funct7 0000001) instructions the single-cycle Execute ALU does not cover.
- Latches operands from the Execute operand muxes (Reg1RD/Reg2RD) and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Holds the pipeline stalled while running, then presents a one-cycle result pulse that the Execute result mux selects in place of ALUresult.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  decoded M-instruction present in Execute (opcode 0110011, funct7 0000001).
- funct3  input  3  instruction[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1  input  XLEN  rs1 value (Reg1RD).
- op2  input  XLEN  rs2 value (Reg2RD).
- flush  input  1  pipeline flush (taken jump/branch); aborts the operation.
- stall  output  1  freeze PC/IF/ID/EX registers.
- result_valid  output  1  one-cycle pulse; result is valid.
- result  output  XLEN  rd write data.

Behaviour:
- Reset: asynchronous on rst_n low. state=IDLE, counter=0, internal accumulators=0, result=0, result_valid=0. A reset mid-operation discards the operation; no result pulse after release.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On start=1 with flush=0: latch funct3 and operands, convert signed operands to magnitudes, record result sign.
  - Special cases go directly to DONE.
  - All other operations go to BUSY with counter=0.
- BUSY:
  - One iteration per cycle.
  - Multiply: 2*XLEN-bit product accumulator, shift-add.
  - Divide: restoring, quotient/remainder shift-subtract.
  - After iteration XLEN-1 (counter==XLEN-1), go to DONE.
- DONE:
  - result_valid=1 for exactly one cycle; result holds the final value.
  - Next state is IDLE.
  - result keeps its value until the next DONE.
- Latency: start seen in cycle 0 gives result_valid in cycle XLEN+1 (33 for default). Special cases give result_valid in cycle 1.
- stall = (state==IDLE & start & ~flush) | (state==BUSY).
  - stall is 0 in DONE, so the pipeline advances on the result_valid cycle and the instruction leaves Execute.
  - start in DONE is a new instruction and is ignored until IDLE, but only if stall has not advanced it. The pipeline guarantees start drops when result_valid=1.
- Result selection:
  - MUL: product[31:0].
  - MULH: signed×signed, high half.
  - MULHSU: signed op1 × unsigned op2, high half.
  - MULHU: unsigned high half.
  - Sign correction is a two's-complement negate of the 64-bit product when the sign bits differ.
  - DIV/REM: quotient takes the sign op1^op2; remainder takes the sign of op1.
- Special cases, per the RISC-V spec; no trap:
  - op2==0: DIV/DIVU result=32'hFFFFFFFF; REM/REMU result=op1.
  - DIV with op1=32'h80000000 and op2=32'hFFFFFFFF: result=32'h80000000; REM in the same case: result=0.
- flush:
  - Any cycle in BUSY or DONE: next state IDLE, result_valid forced 0, result unchanged.
  - flush together with start in IDLE: operation is not accepted.
- start while in BUSY: ignored; operands are not re-latched.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute the product with a single combinational 33×33 signed multiply at the IDLE→DONE transition.
  - result_valid arrives in cycle 1; stall is high only in cycle 0.
  - Divide ops are unchanged.
- Undefined:
  - All multiplies use the iterative BUSY path, 33-cycle latency.
  - No hardware multiplier is inferred.

Test Plan:
- MUL op1=7, op2=6, start 1 cycle → stall high cycles 0–32, result_valid in cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN), result=42.
- MULH op1=32'h80000000, op2=32'h80000000 → result=32'h40000000. MULHSU op1=32'hFFFFFFFF, op2=32'hFFFFFFFF → result=32'hFFFFFFFF.
- DIV op1=-7 (32'hFFFFFFF9), op2=2 → result=32'hFFFFFFFD. REM with the same operands → result=32'hFFFFFFFF. DIVU op1=100, op2=7 → result=14.
- DIVU op2=0 → result_valid in cycle 1, result=32'hFFFFFFFF. REM op1=32'h80000000, op2=32'hFFFFFFFF → result=0, cycle 1.
- DIV started, flush asserted in cycle 10 → state IDLE in cycle 11, stall low, no result_valid pulse; the next MULHU 3×5 gives result=0.
- REMU started, rst_n low in cycle 5 for 2 cycles → stall, result_valid, result all 0 immediately; after release, no pulse without a new start.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// Pipeline <-> RV32M sequencer handshake bundle.
// The pipeline side uses the master modport, the sequencer the slave modport.
interface execute_muldiv_seq_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op1, op2, flush,
                  input  stall, result_valid, result);
  modport slave  (input  start, funct3, op1, op2, flush,
                  output stall, result_valid, result);
endinterface

// File: rtl/execute_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply for MUL* ops.
module execute_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic                clk,
  input logic                rst_n,
  execute_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [2:0]      f3;
  logic [XLEN-1:0] hi, lo, dvs;
  logic            neg;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] res_q;
  logic            valid_q;

  logic            sgn1, sgn2, s1, s2, neg_in;
  logic [XLEN-1:0] mag1, mag2;
  logic            div0, ovf;
  logic [XLEN-1:0] special_res;

  // Operand decode for the instruction waiting in IDLE.
  always_comb begin
    sgn1   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
             (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sgn2   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
             (bus.funct3 == 3'b110);
    s1     = sgn1 & bus.op1[XLEN-1];
    s2     = sgn2 & bus.op2[XLEN-1];
    mag1   = s1 ? -bus.op1 : bus.op1;
    mag2   = s2 ? -bus.op2 : bus.op2;
    case (bus.funct3)
      3'b001, 3'b100: neg_in = s1 ^ s2;
      3'b010, 3'b110: neg_in = s1;
      default:        neg_in = 1'b0;
    endcase
    div0 = bus.funct3[2] && (bus.op2 == '0);
    ovf  = bus.funct3[2] && !bus.funct3[0] &&
           (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
    if (div0)
      special_res = bus.funct3[1] ? bus.op1 : '1;
    else
      special_res = bus.funct3[1] ? '0 : bus.op1;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fp;
  logic [XLEN-1:0]          fast_res;
  always_comb begin
    fa       = {s1 | (sgn1 & bus.op1[XLEN-1]), bus.op1};
    fb       = {s2 | (sgn2 & bus.op2[XLEN-1]), bus.op2};
    fp       = fa * fb;
    fast_res = (bus.funct3 == 3'b000) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]     sum, shifted, diff;
  logic              ge;
  logic [XLEN-1:0]   nhi, nlo, q_c, r_c, fin;
  logic [2*XLEN-1:0] prod, prod_c;

  // hi/lo hold product high/low during multiply, remainder/quotient during divide.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
    ge      = !diff[XLEN];
    if (f3[2]) begin
      nhi = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      nlo = {lo[XLEN-2:0], ge};
    end else begin
      nhi = sum[XLEN:1];
      nlo = {sum[0], lo[XLEN-1:1]};
    end
    prod   = {nhi, nlo};
    prod_c = neg ? -prod : prod;
    q_c    = neg ? -nlo : nlo;
    r_c    = neg ? -nhi : nhi;
    case (f3)
      3'b000:                 fin = prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin = q_c;
      default:                fin = r_c;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      f3      <= '0;
      hi      <= '0;
      lo      <= '0;
      dvs     <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start && !bus.flush) begin
            f3  <= bus.funct3;
            neg <= neg_in;
            cnt <= '0;
            if (div0 || ovf) begin
              res_q   <= special_res;
              valid_q <= 1'b1;
              state   <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!bus.funct3[2]) begin
              res_q   <= fast_res;
              valid_q <= 1'b1;
              state   <= DONE;
            end
`endif
            else begin
              hi    <= '0;
              lo    <= bus.funct3[2] ? mag1 : mag2;
              dvs   <= bus.funct3[2] ? mag2 : mag1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) begin
              res_q   <= fin;
              valid_q <= 1'b1;
              state   <= DONE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall        = ((state == IDLE) && bus.start && !bus.flush) || (state == BUSY);
  assign bus.result_valid = valid_q;
  assign bus.result       = res_q;

endmodule

// File: tb/tb_execute_muldiv_seq.sv
// Directed-vector scoreboard bench for execute_muldiv_seq.
module tb_execute_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic clk, rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  sb_t  sb[$];
  vec_t vt[20];

  execute_muldiv_seq_if #(.XLEN(32)) bus ();
  execute_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every result pulse is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pulse: got result %h, expected no pulse", bus.result);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check(e.name, bus.result, e.exp);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int c, stall_hi;
    bit seen;
    @(negedge clk);
    bus.funct3 = v.f;
    bus.op1    = v.a;
    bus.op2    = v.b;
    bus.flush  = 1'b0;
    bus.start  = 1'b1;
    sb.push_back('{v.exp, v.name});
    #1;
    stall_hi = (bus.stall === 1'b1) ? 1 : 0;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) bus.start = 1'b0;
      #1;
      if (bus.result_valid === 1'b1) begin
        seen = 1'b1;
        check({v.name, "_stall_at_done"}, {31'b0, bus.stall}, 32'd0);
      end else if (bus.stall === 1'b1) begin
        stall_hi++;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no result_valid in 200 cycles, expected cycle %0d", v.name, v.lat);
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      check({v.name, "_latency"}, 32'(c), 32'(v.lat));
      check({v.name, "_stall_cycles"}, 32'(stall_hi), 32'(v.lat));
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.result_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    int pulses;
    vt[0]  = '{3'b000, 32'd7,          32'd6,          32'd42,         ML, "mul_7x6"};
    vt[1]  = '{3'b000, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1,   ML, "mul_neg3x5"};
    vt[2]  = '{3'b001, 32'h80000000,   32'h80000000,   32'h40000000,   ML, "mulh_min_min"};
    vt[3]  = '{3'b001, 32'h80000000,   32'h7FFFFFFF,   32'hC0000000,   ML, "mulh_min_max"};
    vt[4]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   ML, "mulh_m1_m1"};
    vt[5]  = '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   ML, "mulhsu_m1_max"};
    vt[6]  = '{3'b010, 32'h80000000,   32'h80000000,   32'hC0000000,   ML, "mulhsu_min_2p31"};
    vt[7]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   ML, "mulhu_max_max"};
    vt[8]  = '{3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33, "div_m7_2"};
    vt[9]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33, "rem_m7_2"};
    vt[10] = '{3'b100, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33, "div_7_m2"};
    vt[11] = '{3'b110, 32'd7,          32'hFFFFFFFE,   32'd1,          33, "rem_7_m2"};
    vt[12] = '{3'b101, 32'd100,        32'd7,          32'd14,         33, "divu_100_7"};
    vt[13] = '{3'b101, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, "divu_max_1"};
    vt[14] = '{3'b101, 32'd3,          32'd10,         32'd0,          33, "divu_3_10"};
    vt[15] = '{3'b101, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  "divu_by0"};
    vt[16] = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  "rem_ovf"};
    vt[17] = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  "div_ovf"};
    vt[18] = '{3'b111, 32'd1234,       32'd0,          32'd1234,       1,  "remu_by0"};
    vt[19] = '{3'b111, 32'd100,        32'd7,          32'd2,          33, "remu_100_7"};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.funct3 = '0; bus.op1 = '0; bus.op2 = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_stall", {31'b0, bus.stall}, 32'd0);
    check("reset_valid", {31'b0, bus.result_valid}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_vec(vt[i]);

    // Flush a running DIV in cycle 10: no pulse, result keeps the previous value (2).
    @(negedge clk);
    bus.funct3 = 3'b100; bus.op1 = 32'hFFFFFFF9; bus.op2 = 32'd2; bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 10) begin
        bus.flush = 1'b1;
        #1;
        check("flush_stall_c10", {31'b0, bus.stall}, 32'd1);
      end
    end
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_stall_c11", {31'b0, bus.stall}, 32'd0);
    check("flush_result_kept", bus.result, 32'd2);
    count_pulses(40, pulses);
    check("flush_no_pulse", 32'(pulses), 32'd0);
    run_vec('{3'b011, 32'd3, 32'd5, 32'd0, ML, "mulhu_3x5_after_flush"});
    run_vec(vt[19]);

    // Reset in cycle 5 of a REMU: outputs clear at once, no pulse afterwards.
    @(negedge clk);
    bus.funct3 = 3'b111; bus.op1 = 32'd100; bus.op2 = 32'd7; bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midreset_stall", {31'b0, bus.stall}, 32'd0);
    check("midreset_valid", {31'b0, bus.result_valid}, 32'd0);
    check("midreset_result", bus.result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_pulses(40, pulses);
    check("midreset_no_pulse", 32'(pulses), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
